// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: sequences the uart_rx byte receiver and assembles framed commands
// (SYNC, OPCODE, LEN, payload, optional CHK) for the gate-tester core.
// Build option: define UART_CMD_CHECKSUM_EN to include and verify the trailing XOR CHK byte.
module uart_cmd_ctrl #(
   parameter int unsigned MAX_LEN        = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000 / 100,
   localparam int unsigned LW = $clog2(MAX_LEN + 1),
   localparam int unsigned AW = $clog2(MAX_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_done,
   input  logic [7:0]    rx_byte,
   output logic          rx_trigger,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic [7:0]    cmd_opcode,
   output logic [LW-1:0] cmd_len,
   input  logic [AW-1:0] pl_addr,
   output logic [7:0]    pl_data,
   output logic          err_pulse,
   output logic [1:0]    err_code,
   output logic [7:0]    err_count
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      StHunt,
      StOpc,
      StLen,
      StPay,
`ifdef UART_CMD_CHECKSUM_EN
      StChk,
`endif
      StHold
   } state_t;

   // State entered once the last payload byte (or LEN==0) has been taken.
`ifdef UART_CMD_CHECKSUM_EN
   localparam state_t StEnd = StChk;
`else
   localparam state_t StEnd = StHold;
`endif

   state_t          state_q, state_d;
   logic [1:0]      blank_q, blank_d;
   logic            trig_q, trig_d;
   logic [7:0]      opcode_q, opcode_d;
   logic [LW-1:0]   len_q, len_d;
   logic [AW-1:0]   wr_idx_q, wr_idx_d;
   logic [7:0]      chk_q, chk_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            err_pulse_q, err_pulse_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [7:0]      err_count_q, err_count_d;
   logic [7:0]      buffer [MAX_LEN];
   logic            take, in_frame, timeout, buf_we, err;
   logic [1:0]      code;

   // Next-state: byte take, frame parsing, timeout and error bookkeeping.
   always_comb begin
      state_d     = state_q;
      blank_d     = (blank_q != 2'd0) ? blank_q - 2'd1 : 2'd0;
      trig_d      = 1'b0;
      opcode_d    = opcode_q;
      len_d       = len_q;
      wr_idx_d    = wr_idx_q;
      chk_d       = chk_q;
      tmo_d       = '0;
      err_pulse_d = 1'b0;
      err_code_d  = err_code_q;
      err_count_d = err_count_q;
      buf_we      = 1'b0;
      err         = 1'b0;
      code        = 2'd0;

      // blank masks the stale rx_done level until uart_rx has seen the re-arm pulse
      take     = rx_done && (blank_q == 2'd0) && (state_q != StHold);
      in_frame = (state_q != StHunt) && (state_q != StHold);
      timeout  = in_frame && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

      if (take) begin
         blank_d = 2'd2;
         trig_d  = 1'b1;
      end
      if (in_frame && !take) tmo_d = tmo_q + TW'(1);

      if (timeout) begin
         // a byte taken in this cycle is dropped
         err     = 1'b1;
         code    = 2'd3;
         state_d = StHunt;
      end else if (take) begin
         unique case (state_q)
            StHunt: begin
               if (rx_byte == SYNC_BYTE) begin
                  state_d = StOpc;
                  chk_d   = 8'h00;
               end
            end
            StOpc: begin
               opcode_d = rx_byte;
               chk_d    = chk_q ^ rx_byte;
               state_d  = StLen;
            end
            StLen: begin
               if (32'(rx_byte) > MAX_LEN) begin
                  err     = 1'b1;
                  code    = 2'd1;
                  state_d = StHunt;
               end else begin
                  len_d    = rx_byte[LW-1:0];
                  chk_d    = chk_q ^ rx_byte;
                  wr_idx_d = '0;
                  state_d  = (rx_byte == 8'h00) ? StEnd : StPay;
               end
            end
            StPay: begin
               buf_we   = 1'b1;
               chk_d    = chk_q ^ rx_byte;
               wr_idx_d = wr_idx_q + AW'(1);
               if (LW'(wr_idx_q) + LW'(1) == len_q) state_d = StEnd;
            end
`ifdef UART_CMD_CHECKSUM_EN
            StChk: begin
               if (rx_byte == chk_q) begin
                  state_d = StHold;
               end else begin
                  err     = 1'b1;
                  code    = 2'd2;
                  state_d = StHunt;
               end
            end
`endif
            default: ;
         endcase
      end

      if (err) begin
         err_pulse_d = 1'b1;
         err_code_d  = code;
         if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end

      if ((state_q == StHold) && cmd_ready) state_d = StHunt;
   end

   // Control and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StHunt;
         blank_q     <= 2'd0;
         trig_q      <= 1'b0;
         opcode_q    <= 8'h00;
         len_q       <= '0;
         wr_idx_q    <= '0;
         chk_q       <= 8'h00;
         tmo_q       <= '0;
         err_pulse_q <= 1'b0;
         err_code_q  <= 2'd0;
         err_count_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         blank_q     <= blank_d;
         trig_q      <= trig_d;
         opcode_q    <= opcode_d;
         len_q       <= len_d;
         wr_idx_q    <= wr_idx_d;
         chk_q       <= chk_d;
         tmo_q       <= tmo_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
         err_count_q <= err_count_d;
      end
   end

   // Payload buffer; contents are meaningless until a frame fills them, so no reset.
   always_ff @(posedge clk) begin
      if (buf_we) buffer[wr_idx_q] <= rx_byte;
   end

   assign rx_trigger = trig_q;
   assign cmd_valid  = (state_q == StHold);
   assign cmd_opcode = opcode_q;
   assign cmd_len    = len_q;
   assign pl_data    = (LW'(pl_addr) < len_q) ? buffer[pl_addr] : 8'h00;
   assign err_pulse  = err_pulse_q;
   assign err_code   = err_code_q;
   assign err_count  = err_count_q;

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Controller that sequences the uart_rx byte receiver.
- Consumes each completed byte (rx_done/rx_buffer), re-arms the receiver by pulsing rx_trigger, and assembles framed commands for the gate-tester core.
- Frame format: SYNC 0xA5, OPCODE, LEN, LEN payload bytes, CHK.
- Presents each complete command to downstream logic with a valid/ready handshake and a payload read port.

Parameters:
- MAX_LEN, 16: maximum payload bytes; payload buffer depth.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 100_000_000/100: maximum idle clk cycles between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_done  input  1  from uart_rx; high while a received byte is held.
- rx_byte  input  8  from uart_rx rx_buffer.
- rx_trigger  output  1  to uart_rx; one-cycle re-arm pulse.
- cmd_valid  output  1  complete, checked command is available.
- cmd_ready  input  1  downstream accepts the command.
- cmd_opcode  output  8  opcode of the held command.
- cmd_len  output  $clog2(MAX_LEN+1)  payload length of the held command.
- pl_addr  input  $clog2(MAX_LEN)  payload read index.
- pl_data  output  8  payload byte at pl_addr; combinational read, 0 if pl_addr >= cmd_len.
- err_pulse  output  1  one-cycle pulse on a frame error.
- err_code  output  2  last error: 0 none, 1 bad length, 2 checksum, 3 timeout.
- err_count  output  8  saturating count of frame errors.

Behaviour:
- Reset (asynchronous, active-high), all outputs and state cleared:
  - state=HUNT
  - rx_trigger=0, cmd_valid=0, cmd_opcode=0, cmd_len=0
  - err_pulse=0, err_code=0, err_count=0
  - timeout counter=0, blank counter=0, checksum=0
  - Payload buffer contents are don't-care.
- Byte take:
  - take = rx_done & (blank==0) & (state!=HOLD).
  - On take, rx_trigger=1 in the next cycle (registered; exactly one cycle wide).
  - blank is loaded with 2 on take and decrements to 0; this masks the stale rx_done level until uart_rx clears it.
- States:
  - HUNT: take with byte==SYNC_BYTE -> OPC; clear checksum. Any other byte is discarded and the state stays HUNT (not an error).
  - OPC: take -> latch opcode, checksum^=byte -> LEN.
  - LEN: take with byte>MAX_LEN -> error code 1, go to HUNT. Otherwise latch len, checksum^=byte, wr_idx=0. Go to CHK if len==0, else PAY.
  - PAY: take -> buf[wr_idx]=byte, checksum^=byte, wr_idx++. After the byte at index len-1, go to CHK.
  - CHK: take -> if byte==checksum, go to HOLD with cmd_valid=1. Otherwise error code 2, go to HUNT.
  - HOLD: cmd_valid=1; opcode, len and payload are stable. No takes occur, so uart_rx is back-pressured (it stops capturing). cmd_valid & cmd_ready -> cmd_valid=0 next cycle, go to HUNT.
- Checksum: 8-bit XOR of OPCODE, LEN and all payload bytes; SYNC is excluded.
- Timeout:
  - In OPC/LEN/PAY/CHK, the counter increments every cycle and clears on each take.
  - Reaching TIMEOUT_CYCLES -> error code 3, go to HUNT.
  - The counter is held at 0 in HUNT and HOLD.
- Error handling:
  - err_pulse=1 for one cycle.
  - err_code is updated and holds until the next error.
  - err_count increments, saturating at 255.
  - A byte taken in the same cycle that a timeout fires is discarded.
- Latency: cmd_valid rises 1 cycle after the CHK-byte take.
- A reset mid-frame drops the partial frame; a reset in HOLD drops cmd_valid immediately.

Optional Feature:
- UART_CMD_CHECKSUM_EN defined: CHK byte present and checked as above.
- Undefined: there is no CHK byte and no CHK state. The last payload byte, or LEN==0, goes directly to HOLD. Error code 2 never occurs.

Test Plan:
- Bytes A5,10,02,33,44,CHK=0x65 (CHECKSUM_EN) -> cmd_valid=1, opcode=0x10, len=2, pl_data[0]=0x33, [1]=0x44. Six rx_trigger pulses; cmd_ready=1 -> cmd_valid=0, state HUNT.
- Bytes 00,FF,A5,20,00,CHK=0x20 -> leading bytes ignored with no error; cmd_valid with len=0, opcode=0x20.
- A5,01,LEN=MAX_LEN+1 -> err_pulse once, err_code=1, err_count=1; a following valid frame is accepted.
- A5,10,01,55,CHK=0x00 -> err_code=2, no cmd_valid.
- A5,10 then idle for TIMEOUT_CYCLES -> err_code=3; the next A5 is treated as SYNC.
- Hold cmd_ready=0 in HOLD while rx_done=1 -> rx_trigger stays 0. Assert rst mid-PAY -> all outputs 0 and state HUNT.
